remote_ir_decoder: RTL and testbench

REMOTE_IR_DECODER -- requirements
Module: remote_ir_decoder

---
 rtl/remote_ir_decoder.sv | 198 +++++++++++++++++++
 tb/tb_remote_ir_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/remote_ir_decoder.sv
// NEC infrared remote decoder: measures synchronized burst/space widths, assembles
// 32-bit frames LSB first and reports commands, repeat codes and abandoned frames.
module remote_ir_decoder #(
    parameter logic [7:0] ADDRESS    = 8'h00,
    parameter int         TICK_SCALE = 1
) (
    input  logic       clock_50,
    input  logic       reset_key,
    input  logic       ir_in,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       repeat_valid,
    output logic       frame_error
);

    localparam int DIV = (TICK_SCALE < 32'sd1) ? 32'sd1 : TICK_SCALE;

    localparam logic [19:0] LEAD_LOW_MIN  = 20'(32'sd400000 / DIV);
    localparam logic [19:0] LEAD_LOW_MAX  = 20'(32'sd500000 / DIV);
    localparam logic [19:0] LEAD_HIGH_MIN = 20'(32'sd200000 / DIV);
    localparam logic [19:0] LEAD_HIGH_MAX = 20'(32'sd250000 / DIV);
    localparam logic [19:0] REP_HIGH_MIN  = 20'(32'sd100000 / DIV);
    localparam logic [19:0] REP_HIGH_MAX  = 20'(32'sd125000 / DIV);
    localparam logic [19:0] BIT_LOW_MIN   = 20'(32'sd20000 / DIV);
    localparam logic [19:0] BIT_LOW_MAX   = 20'(32'sd36000 / DIV);
    localparam logic [19:0] BIT0_MIN      = 20'(32'sd20000 / DIV);
    localparam logic [19:0] BIT0_MAX      = 20'(32'sd36000 / DIV);
    localparam logic [19:0] BIT1_MIN      = 20'(32'sd70000 / DIV);
    localparam logic [19:0] BIT1_MAX      = 20'(32'sd100000 / DIV);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LEAD_LOW  = 3'd1,
        S_LEAD_HIGH = 3'd2,
        S_BIT_LOW   = 3'd3,
        S_BIT_HIGH  = 3'd4,
        S_CHECK     = 3'd5
    } state_t;

    function automatic logic in_win(input logic [19:0] v,
                                    input logic [19:0] lo,
                                    input logic [19:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic frame_ok(input logic [31:0] f);
        return (f[7:0] == ADDRESS) && (f[15:8] == ~f[7:0]) && (f[31:24] == ~f[23:16]);
    endfunction

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_ir_d;
    logic [19:0] r_cnt;
    logic [31:0] r_shift;
    logic [4:0]  r_bit_idx;
    logic        r_last_ok;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_code;
    logic        r_repeat_valid;
    logic        r_frame_error;

    logic        w_fall;
    logic        w_rise;
    logic        w_timeout;
    logic        w_is_zero;
    logic        w_is_one;

    assign w_fall    = r_ir_d & ~r_sync2;
    assign w_rise    = ~r_ir_d & r_sync2;
    assign w_is_zero = in_win(r_cnt, BIT0_MIN, BIT0_MAX);
    assign w_is_one  = in_win(r_cnt, BIT1_MIN, BIT1_MAX);

    assign cmd_valid    = r_cmd_valid;
    assign cmd_code     = r_cmd_code;
    assign repeat_valid = r_repeat_valid;
    assign frame_error  = r_frame_error;

    // Two-flop synchronizer plus one delay stage for edge detection (idle high).
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_ir_d  <= 1'b1;
        end else begin
            r_sync1 <= ir_in;
            r_sync2 <= r_sync1;
            r_ir_d  <= r_sync2;
        end
    end

    // Phase-width counter: restarts on each synchronized edge, saturates at all-ones.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_cnt <= 20'd0;
        end else if (w_fall || w_rise) begin
            r_cnt <= 20'd0;
        end else if (r_cnt != 20'hFFFFF) begin
            r_cnt <= r_cnt + 20'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Per-state upper bound; exceeding it abandons the frame without waiting for an edge.
    always_comb begin
        w_timeout = 1'b0;
        case (r_state)
            S_LEAD_LOW:  w_timeout = (r_cnt > LEAD_LOW_MAX);
            S_LEAD_HIGH: w_timeout = (r_cnt > LEAD_HIGH_MAX);
            S_BIT_LOW:   w_timeout = (r_cnt > BIT_LOW_MAX);
            S_BIT_HIGH:  w_timeout = (r_cnt > BIT1_MAX);
            default:     w_timeout = 1'b0;
        endcase
    end

    // Decoder FSM with registered strobes; strobes default low so each lasts one cycle.
    always_ff @(posedge clock_50 or negedge reset_key) begin
        if (!reset_key) begin
            r_state        <= S_IDLE;
            r_shift        <= 32'd0;
            r_bit_idx      <= 5'd0;
            r_last_ok      <= 1'b0;
            r_cmd_valid    <= 1'b0;
            r_cmd_code     <= 8'h00;
            r_repeat_valid <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_cmd_valid    <= 1'b0;
            r_repeat_valid <= 1'b0;
            r_frame_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_LEAD_LOW;
                    end
                end
                S_LEAD_LOW: begin
                    if (w_rise && in_win(r_cnt, LEAD_LOW_MIN, LEAD_LOW_MAX)) begin
                        r_state <= S_LEAD_HIGH;
                    end else if (w_rise || w_timeout) begin
                        r_frame_error <= 1'b1;
                        r_last_ok     <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_LEAD_HIGH: begin
                    if (w_fall && in_win(r_cnt, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
                        r_bit_idx <= 5'd0;
                        r_state   <= S_BIT_LOW;
                    end else if (w_fall && in_win(r_cnt, REP_HIGH_MIN, REP_HIGH_MAX)) begin
                        r_repeat_valid <= r_last_ok;
                        r_state        <= S_IDLE;
                    end else if (w_fall || w_timeout) begin
                        r_frame_error <= 1'b1;
                        r_last_ok     <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_BIT_LOW: begin
                    if (w_rise && in_win(r_cnt, BIT_LOW_MIN, BIT_LOW_MAX)) begin
                        r_state <= S_BIT_HIGH;
                    end else if (w_rise || w_timeout) begin
                        r_frame_error <= 1'b1;
                        r_last_ok     <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_BIT_HIGH: begin
                    if (w_fall && (w_is_zero || w_is_one)) begin
                        r_shift   <= {w_is_one, r_shift[31:1]};
                        r_bit_idx <= r_bit_idx + 5'd1;
                        r_state   <= (r_bit_idx == 5'd31) ? S_CHECK : S_BIT_LOW;
                    end else if (w_fall || w_timeout) begin
                        r_frame_error <= 1'b1;
                        r_last_ok     <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (frame_ok(r_shift)) begin
                        r_cmd_code  <= r_shift[23:16];
                        r_cmd_valid <= 1'b1;
                        r_last_ok   <= 1'b1;
                    end else begin
                        r_frame_error <= 1'b1;
                        r_last_ok     <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remote_ir_decoder.sv
// Self-checking bench for remote_ir_decoder: directed NEC scenarios followed by
// randomized transactions scored against a transaction-level model.
module tb_remote_ir_decoder;

    localparam int SCALE = 1000;
    localparam logic [7:0] ADDR = 8'h00;

    logic       clock_50 = 1'b0;
    logic       reset_key = 1'b0;
    logic       ir_in = 1'b1;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       repeat_valid;
    logic       frame_error;

    remote_ir_decoder #(.ADDRESS(ADDR), .TICK_SCALE(SCALE)) dut (
        .clock_50     (clock_50),
        .reset_key    (reset_key),
        .ir_in        (ir_in),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .repeat_valid (repeat_valid),
        .frame_error  (frame_error)
    );

    always #10 clock_50 = ~clock_50;

    int   checks = 0;
    int   errors = 0;
    int   n_cmd = 0, n_rep = 0, n_err = 0, n_viol = 0;
    logic prev_any = 1'b0;
    time  t_err = 0;

    // Strobe monitor: counts pulses and flags overlapping or back-to-back strobes.
    always @(negedge clock_50) begin
        if (cmd_valid)    n_cmd <= n_cmd + 1;
        if (repeat_valid) n_rep <= n_rep + 1;
        if (frame_error) begin
            n_err <= n_err + 1;
            t_err <= $time;
        end
        if ((int'(cmd_valid) + int'(repeat_valid) + int'(frame_error)) > 1 ||
            ((cmd_valid | repeat_valid | frame_error) && prev_any))
            n_viol <= n_viol + 1;
        prev_any <= cmd_valid | repeat_valid | frame_error;
    end

    // Reference model state: what the decoder should remember between transactions.
    logic [7:0] m_code;
    logic       m_last_ok;
    int         c0, r0, x0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        ir_in = v;
        repeat (n) @(negedge clock_50);
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    task automatic send_leader(input int hi);
        hold(1'b0, int'($urandom_range(495, 405)));
        hold(1'b1, hi);
    endtask

    task automatic send_bits(input logic [31:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, int'($urandom_range(33, 23)));
            hold(1'b1, f[i] ? int'($urandom_range(97, 73)) : int'($urandom_range(33, 23)));
        end
    endtask

    task automatic send_frame(input logic [31:0] f);
        send_leader(int'($urandom_range(245, 205)));
        send_bits(f, 32);
        hold(1'b0, 28);
        hold(1'b1, 150);
    endtask

    task automatic send_repeat();
        hold(1'b0, int'($urandom_range(495, 405)));
        hold(1'b1, int'($urandom_range(120, 105)));
        hold(1'b0, 28);
        hold(1'b1, 150);
    endtask

    task automatic snap();
        c0 = n_cmd; r0 = n_rep; x0 = n_err;
    endtask

    task automatic expect_txn(input string tag, input int e_cmd, input int e_rep, input int e_err);
        chk({tag, ".cmd_valid_pulses"},    32'(n_cmd - c0), 32'(e_cmd));
        chk({tag, ".repeat_valid_pulses"}, 32'(n_rep - r0), 32'(e_rep));
        chk({tag, ".frame_error_pulses"},  32'(n_err - x0), 32'(e_err));
        chk({tag, ".cmd_code"},            32'(cmd_code),   32'(m_code));
    endtask

    // Frame rule from the protocol: address match and both complement bytes.
    task automatic do_frame(input string tag, input logic [31:0] f);
        logic ok;
        ok = (f[7:0] == ADDR) && (f[15:8] == ~f[7:0]) && (f[31:24] == ~f[23:16]);
        snap();
        send_frame(f);
        if (ok) begin
            m_code = f[23:16];
            m_last_ok = 1'b1;
        end else begin
            m_last_ok = 1'b0;
        end
        expect_txn(tag, ok ? 1 : 0, 0, ok ? 0 : 1);
    endtask

    task automatic do_repeat(input string tag);
        snap();
        send_repeat();
        expect_txn(tag, 0, m_last_ok ? 1 : 0, 0);
    endtask

    task automatic do_bad_timing(input string tag, input int variant);
        int k;
        k = int'($urandom_range(31, 0));
        snap();
        case (variant)
            0: begin hold(1'b0, 300); hold(1'b1, 150); end
            1: begin hold(1'b0, 450); hold(1'b1, 160); hold(1'b0, 28); hold(1'b1, 150); end
            2: begin
                send_leader(225); send_bits($urandom, k);
                hold(1'b0, 28); hold(1'b1, 50); hold(1'b0, 28); hold(1'b1, 150);
            end
            default: begin
                send_leader(225); send_bits($urandom, k);
                hold(1'b0, 45); hold(1'b1, 150);
            end
        endcase
        m_last_ok = 1'b0;
        expect_txn(tag, 0, 0, 1);
    endtask

    initial begin
        time t0;
        int  dt;
        logic [31:0] f;
        logic [7:0]  mask;

        reset_key = 1'b0;
        ir_in = 1'b1;
        repeat (5) @(negedge clock_50);
        chk("reset.cmd_valid",    32'(cmd_valid),    32'd0);
        chk("reset.repeat_valid", 32'(repeat_valid), 32'd0);
        chk("reset.frame_error",  32'(frame_error),  32'd0);
        chk("reset.cmd_code",     32'(cmd_code),     32'h00);
        reset_key = 1'b1;
        m_code = 8'h00;
        m_last_ok = 1'b0;
        repeat (10) @(negedge clock_50);

        do_repeat("repeat_after_reset");
        do_frame("frame_45", 32'hBA45FF00);
        do_repeat("repeat_after_45");
        do_frame("frame_bad_byte3", 32'hBB45FF00);
        do_repeat("repeat_after_error");

        // Over-long leader: abandoned once the low phase passes its upper bound.
        snap();
        hold(1'b0, 1);
        t0 = $time - 20;
        hold(1'b0, 599);
        hold(1'b1, 150);
        dt = int'((t_err - t0) / 20);
        m_last_ok = 1'b0;
        expect_txn("long_leader", 0, 0, 1);
        chk("long_leader.error_cycle_in_range", 32'((dt >= 500) && (dt <= 508)), 32'd1);
        do_frame("frame_after_long_leader", mk(ADDR, 8'h12));

        // Reset in the middle of a frame discards it silently.
        snap();
        send_leader(225);
        send_bits(32'hE718FF00, 16);
        reset_key = 1'b0;
        repeat (5) @(negedge clock_50);
        reset_key = 1'b1;
        repeat (20) @(negedge clock_50);
        m_code = 8'h00;
        m_last_ok = 1'b0;
        expect_txn("reset_mid_frame", 0, 0, 0);
        do_frame("frame_18", 32'hE718FF00);

        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(3, 0))
                0: do_frame("rand_valid", mk(ADDR, 8'($urandom)));
                1: begin
                    f = mk(ADDR, 8'($urandom));
                    mask = 8'($urandom_range(255, 1));
                    case ($urandom_range(2, 0))
                        0: f[7:0]   = f[7:0] ^ mask;
                        1: f[15:8]  = f[15:8] ^ mask;
                        default: f[31:24] = f[31:24] ^ mask;
                    endcase
                    do_frame("rand_corrupt", f);
                end
                2: do_repeat("rand_repeat");
                default: do_bad_timing("rand_bad_timing", int'($urandom_range(3, 0)));
            endcase
        end

        chk("strobe_exclusive_violations", 32'(n_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
